// File: rtl/cpu_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : cpu_alu_mc
// Description : Multi-cycle ALU with valid/ready handshakes. Single-cycle ops
//               (add/sub/logic/load-half/shifts) finish one cycle after
//               accept; MUL (shift-add) and DIVU/REMU (restoring division)
//               iterate one bit per cycle for REG_WIDTH cycles. Result and
//               flags are registered and held until the consumer takes them.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_alu_mc #(
    parameter int REG_WIDTH  = 16,
    parameter bit MUL_ENABLE = 1'b1,
    parameter bit DIV_ENABLE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [3:0]             i_op,
    input  logic [REG_WIDTH-1:0]   i_rs1_value,
    input  logic [REG_WIDTH-1:0]   i_rs2_value,
    input  logic [REG_WIDTH/2-1:0] i_imm,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [REG_WIDTH-1:0]   o_result,
    output logic                   o_eq,
    output logic                   o_gt,
    output logic                   o_lt,
    output logic                   o_carry,
    output logic                   o_div_zero
);

    localparam int IMM_WIDTH = REG_WIDTH / 2;
    localparam int SHW       = $clog2(REG_WIDTH);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_LH   = 4'd5;
    localparam logic [3:0] c_OP_LL   = 4'd6;
    localparam logic [3:0] c_OP_SHL  = 4'd7;
    localparam logic [3:0] c_OP_SHR  = 4'd8;
    localparam logic [3:0] c_OP_SRA  = 4'd9;
    localparam logic [3:0] c_OP_MUL  = 4'd10;
    localparam logic [3:0] c_OP_DIVU = 4'd11;
    localparam logic [3:0] c_OP_REMU = 4'd12;

    localparam logic [SHW-1:0] c_LAST_ITER = SHW'(REG_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } t_state;

    t_state                 r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [REG_WIDTH-1:0]   r_result;
    logic                   r_eq;
    logic                   r_gt;
    logic                   r_lt;
    logic                   r_carry;
    logic                   r_div_zero;

    // Iteration datapath: r_acc is the product accumulator or the partial
    // remainder; r_x is the multiplier (shifted right) or the dividend that
    // turns into the quotient (shifted left); r_y is the multiplicand
    // (shifted left) or the fixed divisor.
    logic                   r_is_mul;
    logic                   r_is_rem;
    logic [SHW-1:0]         r_cnt;
    logic [REG_WIDTH-1:0]   r_acc;
    logic [REG_WIDTH-1:0]   r_x;
    logic [REG_WIDTH-1:0]   r_y;

    logic [REG_WIDTH-1:0]   w_res;
    logic                   w_carry;
    logic [REG_WIDTH:0]     w_sum;
    logic [SHW-1:0]         w_amt;
    logic                   w_is_mul;
    logic                   w_is_div;
    logic [REG_WIDTH-1:0]   w_mul_acc;
    logic [REG_WIDTH:0]     w_rem_sh;
    logic [REG_WIDTH:0]     w_rem_diff;
    logic                   w_rem_ge;
    logic [REG_WIDTH-1:0]   w_div_rem;
    logic [REG_WIDTH-1:0]   w_div_quo;

    assign w_is_mul = MUL_ENABLE && (i_op == c_OP_MUL);
    assign w_is_div = DIV_ENABLE && ((i_op == c_OP_DIVU) || (i_op == c_OP_REMU));
    assign w_sum    = {1'b0, i_rs1_value} + {1'b0, i_rs2_value};
    assign w_amt    = i_rs2_value[SHW-1:0];

    // Single-cycle result computed straight from the request; illegal or
    // multi-cycle opcodes fall to the zero default.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (i_op)
            c_OP_ADD: begin
                w_res   = w_sum[REG_WIDTH-1:0];
                w_carry = w_sum[REG_WIDTH];
            end
            c_OP_SUB: begin
                w_res   = i_rs1_value - i_rs2_value;
                w_carry = (i_rs1_value < i_rs2_value);
            end
            c_OP_AND: w_res = i_rs1_value & i_rs2_value;
            c_OP_OR:  w_res = i_rs1_value | i_rs2_value;
            c_OP_XOR: w_res = i_rs1_value ^ i_rs2_value;
            c_OP_LH:  w_res = {i_imm, i_rs1_value[IMM_WIDTH-1:0]};
            c_OP_LL:  w_res = {i_rs1_value[REG_WIDTH-1:IMM_WIDTH], i_imm};
            c_OP_SHL: w_res = i_rs1_value << w_amt;
            c_OP_SHR: w_res = i_rs1_value >> w_amt;
            c_OP_SRA: w_res = $unsigned($signed(i_rs1_value) >>> w_amt);
            default:  w_res = '0;
        endcase
    end

    // One shift-add step and one restoring-division step. A zero divisor
    // always "fits", giving an all-ones quotient and the dividend as remainder.
    assign w_mul_acc  = r_acc + (r_x[0] ? r_y : '0);
    assign w_rem_sh   = {r_acc, r_x[REG_WIDTH-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_y};
    assign w_rem_ge   = ~w_rem_diff[REG_WIDTH];
    assign w_div_rem  = w_rem_ge ? w_rem_diff[REG_WIDTH-1:0] : w_rem_sh[REG_WIDTH-1:0];
    assign w_div_quo  = {r_x[REG_WIDTH-2:0], w_rem_ge};

    // Control FSM with registered handshakes, result and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_carry     <= 1'b0;
            r_div_zero  <= 1'b0;
            r_is_mul    <= 1'b0;
            r_is_rem    <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_x         <= '0;
            r_y         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_eq       <= (i_rs1_value == i_rs2_value);
                        r_gt       <= (i_rs1_value >  i_rs2_value);
                        r_lt       <= (i_rs1_value <  i_rs2_value);
                        r_carry    <= w_carry;
                        r_div_zero <= w_is_div && (i_rs2_value == '0);
                        r_in_ready <= 1'b0;
                        if (w_is_mul || w_is_div) begin
                            r_state  <= S_BUSY;
                            r_is_mul <= w_is_mul;
                            r_is_rem <= (i_op == c_OP_REMU);
                            r_cnt    <= '0;
                            r_acc    <= '0;
                            r_x      <= w_is_mul ? i_rs2_value : i_rs1_value;
                            r_y      <= w_is_mul ? i_rs1_value : i_rs2_value;
                        end else begin
                            r_state     <= S_DONE;
                            r_result    <= w_res;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_mul) begin
                        r_acc <= w_mul_acc;
                        r_x   <= r_x >> 1;
                        r_y   <= r_y << 1;
                    end else begin
                        r_acc <= w_div_rem;
                        r_x   <= w_div_quo;
                    end
                    if (r_cnt == c_LAST_ITER) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= r_is_mul ? w_mul_acc
                                                : (r_is_rem ? w_div_rem : w_div_quo);
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_eq        = r_eq;
    assign o_gt        = r_gt;
    assign o_lt        = r_lt;
    assign o_carry     = r_carry;
    assign o_div_zero  = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_cpu_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_alu_mc
// Description : Self-checking bench for cpu_alu_mc (REG_WIDTH=16) with a
//               behavioural reference model, directed literal cases and
//               randomized operations with random back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_alu_mc;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_in_valid = 1'b0;
    logic          o_in_ready;
    logic [3:0]    i_op = '0;
    logic [W-1:0]  i_rs1_value = '0;
    logic [W-1:0]  i_rs2_value = '0;
    logic [W/2-1:0] i_imm = '0;
    logic          o_out_valid;
    logic          i_out_ready = 1'b1;
    logic [W-1:0]  o_result;
    logic          o_eq, o_gt, o_lt, o_carry, o_div_zero;

    int n_vec = 0;
    int n_err = 0;

    cpu_alu_mc #(.REG_WIDTH(W), .MUL_ENABLE(1'b1), .DIV_ENABLE(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_op        (i_op),
        .i_rs1_value (i_rs1_value),
        .i_rs2_value (i_rs2_value),
        .i_imm       (i_imm),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_result    (o_result),
        .o_eq        (o_eq),
        .o_gt        (o_gt),
        .o_lt        (o_lt),
        .o_carry     (o_carry),
        .o_div_zero  (o_div_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          multi;
        logic [4:0]    flags;   // {eq, gt, lt, carry, div_zero}
        logic [15:0]   res;
    } exp_t;

    // Reference: what the ALU must produce, from plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input int unsigned a,
                                   input int unsigned b, input int unsigned imm);
        exp_t        e;
        int unsigned r;
        int          sa;
        int unsigned amt;
        logic        cy;
        logic        dz;
        amt = b % 16;
        r   = 0;
        cy  = 1'b0;
        dz  = 1'b0;
        e.multi = (op == 4'd10) || (op == 4'd11) || (op == 4'd12);
        case (op)
            4'd0:  begin r = a + b; cy = (r > 32'hFFFF); end
            4'd1:  begin r = a - b; cy = (a < b); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = imm * 256 + (a % 256);
            4'd6:  r = (a / 256) * 256 + imm;
            4'd7:  r = a << amt;
            4'd8:  r = a >> amt;
            4'd9:  begin
                sa = int'(a);
                if (a >= 32768) sa = sa - 65536;
                r = int'(sa >>> amt);
            end
            4'd10: r = a * b;
            4'd11: begin dz = (b == 0); r = (b == 0) ? 32'hFFFF : a / b; end
            4'd12: begin dz = (b == 0); r = (b == 0) ? a : a % b; end
            default: r = 0;
        endcase
        e.res   = r[15:0];
        e.flags = {a == b, a > b, a < b, cy, dz};
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model of the handshake: latency in edges, not FSM states.
    exp_t m_exp;
    logic m_in_ready  = 1'b1;
    logic m_out_valid = 1'b0;
    int   m_left      = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_in_ready  = 1'b1;
            m_out_valid = 1'b0;
            m_left      = 0;
        end else begin
            check("in_ready", {31'd0, o_in_ready}, {31'd0, m_in_ready});
            check("out_valid", {31'd0, o_out_valid}, {31'd0, m_out_valid});
            if (m_out_valid) begin
                check("result", {16'd0, o_result}, {16'd0, m_exp.res});
                check("flags", {27'd0, o_eq, o_gt, o_lt, o_carry, o_div_zero},
                      {27'd0, m_exp.flags});
            end
            if (m_in_ready && i_in_valid) begin
                m_exp      = model(i_op, i_rs1_value, i_rs2_value, i_imm);
                m_in_ready = 1'b0;
                if (m_exp.multi) m_left = W;
                else             m_out_valid = 1'b1;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_out_valid = 1'b1;
            end else if (m_out_valid && i_out_ready) begin
                m_out_valid = 1'b0;
                m_in_ready  = 1'b1;
            end
        end
    end

    // Issue one op, wait for its result, apply `hold` stall cycles, consume it.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] imm, input int hold,
                          output logic [15:0] res, output logic [4:0] flags, output int lat);
        int n;
        @(posedge clk); #1;
        i_in_valid  = 1'b1;
        i_op        = op;
        i_rs1_value = a;
        i_rs2_value = b;
        i_imm       = imm;
        i_out_ready = (hold == 0);
        n = 0;
        while (!o_in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        // Scramble inputs after accept; a held in_valid must be ignored.
        i_in_valid  = $urandom_range(0, 1);
        i_op        = 4'($urandom);
        i_rs1_value = 16'($urandom);
        i_rs2_value = 16'($urandom);
        i_imm       = 8'($urandom);
        lat = 1;
        while (!o_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        i_in_valid = 1'b0;
        if (lat >= 40) check("result_timeout", 32'd1, 32'd0);
        res   = o_result;
        flags = {o_eq, o_gt, o_lt, o_carry, o_div_zero};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_result", {16'd0, o_result}, {16'd0, res});
            check("hold_in_ready", {31'd0, o_in_ready}, 32'd0);
        end
        i_out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] res;
        logic [4:0]  fl;
        int          lat;
        exp_t        e;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
        check("rst_result", {16'd0, o_result}, 32'd0);
        check("rst_flags", {27'd0, o_eq, o_gt, o_lt, o_carry, o_div_zero}, 32'd0);

        // Hand-computed literals that also pin the model.
        e = model(4'd1, 3, 5, 0);
        check("model_sub", {16'd0, e.res}, 32'hFFFE);
        e = model(4'd9, 16'h8000, 4, 0);
        check("model_sra", {16'd0, e.res}, 32'hF800);

        run_op(4'd0, 16'hFFFF, 16'h0001, 8'h00, 0, res, fl, lat);
        check("add_res", {16'd0, res}, 32'h0000);
        check("add_flags", {27'd0, fl}, {27'd0, 5'b01010});
        check("add_lat", lat, 1);
        run_op(4'd1, 16'h0003, 16'h0005, 8'h00, 1, res, fl, lat);
        check("sub_res", {16'd0, res}, 32'hFFFE);
        check("sub_flags", {27'd0, fl}, {27'd0, 5'b00110});
        run_op(4'd5, 16'h1234, 16'h0000, 8'hAB, 0, res, fl, lat);
        check("lh_res", {16'd0, res}, 32'hAB34);
        run_op(4'd6, 16'h1234, 16'h0000, 8'hAB, 0, res, fl, lat);
        check("ll_res", {16'd0, res}, 32'h12AB);
        run_op(4'd7, 16'h0001, 16'h0013, 8'h00, 0, res, fl, lat);
        check("shl_res", {16'd0, res}, 32'h0008);
        run_op(4'd9, 16'h8000, 16'h0004, 8'h00, 0, res, fl, lat);
        check("sra_res", {16'd0, res}, 32'hF800);
        run_op(4'd8, 16'h8000, 16'h0004, 8'h00, 0, res, fl, lat);
        check("shr_res", {16'd0, res}, 32'h0800);
        run_op(4'd10, 16'h0123, 16'h0100, 8'h00, 5, res, fl, lat);
        check("mul_res", {16'd0, res}, 32'h2300);
        check("mul_lat", lat, 17);
        run_op(4'd11, 16'd100, 16'd7, 8'h00, 0, res, fl, lat);
        check("divu_res", {16'd0, res}, 32'd14);
        check("divu_lat", lat, 17);
        run_op(4'd12, 16'd100, 16'd7, 8'h00, 0, res, fl, lat);
        check("remu_res", {16'd0, res}, 32'd2);
        run_op(4'd11, 16'd9, 16'd0, 8'h00, 0, res, fl, lat);
        check("divz_res", {16'd0, res}, 32'hFFFF);
        check("divz_flag", {31'd0, fl[0]}, 32'd1);
        run_op(4'd12, 16'd9, 16'd0, 8'h00, 2, res, fl, lat);
        check("remz_res", {16'd0, res}, 32'd9);
        check("remz_flag", {31'd0, fl[0]}, 32'd1);
        run_op(4'd14, 16'h0005, 16'h0003, 8'h00, 0, res, fl, lat);
        check("illegal_res", {16'd0, res}, 32'd0);
        check("illegal_lat", lat, 1);
        check("illegal_flags", {27'd0, fl}, {27'd0, 5'b01000});

        // Reset during the fifth MUL iteration aborts the operation.
        @(posedge clk); #1;
        i_in_valid  = 1'b1;
        i_op        = 4'd10;
        i_rs1_value = 16'd3;
        i_rs2_value = 16'd5;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("abort_out_valid", {31'd0, o_out_valid}, 32'd0);
        end
        check("abort_in_ready", {31'd0, o_in_ready}, 32'd1);
        check("abort_result", {16'd0, o_result}, 32'd0);

        // Randomized operations with biased operands and random stalls.
        for (int k = 0; k < 250; k++) begin
            logic [15:0] a, b;
            logic [3:0]  op;
            a  = 16'($urandom);
            b  = 16'($urandom);
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: b = 16'h0000;
                1: b = a;
                2: a = 16'hFFFF;
                3: b = 16'($urandom_range(0, 20));
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_op(op, a, b, 8'($urandom), int'($urandom_range(0, 2)), res, fl, lat);
            check("rand_lat", lat, ((op >= 4'd10) && (op <= 4'd12)) ? 17 : 1);
        end

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
